universal_shift_register_burst: RTL and testbench



---
 rtl/universal_shift_register_burst.sv | 148 ++++++++++++++
 tb/tb_universal_shift_register_burst.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register_burst.sv
// Universal N-bit shift register with serial in/out, rotate and arithmetic
// shift, plus a counted burst engine that repeats one shift-class op.
module universal_shift_register_burst #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     data,
    input  logic [2:0]       ctrl,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic [N-1:0]     out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {StIdle, StBurst} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       reg_q, reg_d;
    logic               sout_q, sout_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;

    logic [2:0]         op_sel;
    logic [N-1:0]       step_r;
    logic               step_sout;
    logic               shift_class;

    // One-step datapath: the latched op drives it during a burst, ctrl otherwise.
    always_comb begin
        op_sel    = (state_q == StBurst) ? op_q : ctrl;
        step_r    = reg_q;
        step_sout = sout_q;
        case (op_sel)
            3'b001: begin
                step_r    = {reg_q[N-2:0], sin_r};
                step_sout = reg_q[N-1];
            end
            3'b010: begin
                step_r    = {sin_l, reg_q[N-1:1]};
                step_sout = reg_q[0];
            end
            3'b011: begin
                step_r    = data;
            end
            3'b100: begin
                step_r    = {reg_q[N-2:0], reg_q[N-1]};
                step_sout = reg_q[N-1];
            end
            3'b101: begin
                step_r    = {reg_q[0], reg_q[N-1:1]};
                step_sout = reg_q[0];
            end
            3'b110: begin
                step_r    = {reg_q[N-1], reg_q[N-1:1]};
                step_sout = reg_q[0];
            end
            default: begin
                step_r    = reg_q;
                step_sout = sout_q;
            end
        endcase
    end

    // Only shifts and rotates may be repeated as a burst.
    always_comb begin
        shift_class = 1'b0;
        case (ctrl)
            3'b001, 3'b010, 3'b100, 3'b101, 3'b110: shift_class = 1'b1;
            default:                                 shift_class = 1'b0;
        endcase
    end

    // Next-state logic: single-step in idle, counted repetition in burst.
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            StIdle: begin
                if (start && shift_class) begin
                    if (count != '0) begin
                        op_d    = ctrl;
                        cnt_d   = count;
                        state_d = StBurst;
                    end else begin
                        // Zero-length burst completes immediately.
                        done_d = 1'b1;
                    end
                end else begin
                    reg_d  = step_r;
                    sout_d = step_sout;
                end
            end
            StBurst: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    reg_d  = step_r;
                    sout_d = step_sout;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            reg_q   <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign out  = reg_q;
    assign sout = sout_q;
    assign busy = (state_q == StBurst);
    assign done = done_q;

endmodule

// File: tb/tb_universal_shift_register_burst.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model that tracks the register value and remaining burst steps.
module tb_universal_shift_register_burst;

    localparam int unsigned N     = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     data = '0;
    logic [2:0]       ctrl = '0;
    logic             sin_r = 1'b0;
    logic             sin_l = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic             abort = 1'b0;
    logic [N-1:0]     out;
    logic             sout;
    logic             busy;
    logic             done;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [N-1:0] m_out  = '0;
    logic         m_sout = 1'b0;
    logic         m_done = 1'b0;
    int           m_left = 0;
    logic [2:0]   m_op   = '0;

    universal_shift_register_burst #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .ctrl  (ctrl),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .start (start),
        .count (count),
        .abort (abort),
        .out   (out),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic bit is_shift(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5) || (op == 3'd6);
    endfunction

    // Apply one operation arithmetically to the model value.
    task automatic model_apply(input logic [2:0] op, inout logic [N-1:0] v, inout logic s);
        logic [N-1:0] lsb_one;
        logic [N-1:0] orig;
        orig    = v;
        lsb_one = {{(N-1){1'b0}}, sin_l};
        case (op)
            3'd1: begin v = (orig << 1) | N'(sin_r);           s = orig[N-1]; end
            3'd2: begin v = (orig >> 1) | (lsb_one << (N-1)); s = orig[0];   end
            3'd3: begin v = data; end
            3'd4: begin v = (orig << 1) | (orig >> (N-1));    s = orig[N-1]; end
            3'd5: begin v = (orig >> 1) | (orig << (N-1));    s = orig[0];   end
            3'd6: begin v = N'($signed(orig) >>> 1);          s = orig[0];   end
            default: ;
        endcase
    endtask

    // Advance model and DUT by one clock; outputs are sampled 1 time unit later.
    task automatic tick();
        logic [N-1:0] v;
        logic         s;
        logic         d;
        int           left;
        logic [2:0]   op;
        v = m_out; s = m_sout; d = 1'b0; left = m_left; op = m_op;
        if (reset) begin
            v = '0; s = 1'b0; left = 0; op = '0;
        end else if (left > 0) begin
            if (abort) begin
                left = 0;
            end else begin
                model_apply(op, v, s);
                left = left - 1;
                d = (left == 0);
            end
        end else if (start && is_shift(ctrl)) begin
            if (count != 0) begin
                left = int'(count);
                op   = ctrl;
            end else begin
                d = 1'b1;
            end
        end else begin
            model_apply(ctrl, v, s);
        end
        @(posedge clk);
        #1;
        m_out = v; m_sout = s; m_done = d; m_left = left; m_op = op;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ctrl = 3'b011; data = 8'hA5;
        tick();
        ctrl = 3'b100; start = 1'b1; count = 4'd4;
        tick();
        start = 1'b0; ctrl = 3'b000;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (out !== 8'h00 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out=%h sout=%b busy=%b done=%b, required 00 0 0 0",
                     out, sout, busy, done);
        end
    endtask

    task automatic test_single_step();
        ctrl = 3'b011; data = 8'hA5;
        tick();
        ctrl = 3'b001; sin_r = 1'b1;
        tick();
        n_cmp++;
        if (out !== 8'h4B || sout !== 1'b1) begin
            n_fail++;
            $display("FAIL shl: out=%h sout=%b, required 4b 1", out, sout);
        end
        ctrl = 3'b111; sin_r = 1'b0;
        tick();
        n_cmp++;
        if (out !== 8'h4B || sout !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_hold: out=%h sout=%b, required 4b 1", out, sout);
        end
        ctrl = 3'b011; data = 8'h96;
        tick();
        ctrl = 3'b110;
        tick();
        n_cmp++;
        if (out !== 8'hCB || sout !== 1'b0) begin
            n_fail++;
            $display("FAIL asr: out=%h sout=%b, required cb 0", out, sout);
        end
        ctrl = 3'b011; data = 8'h96;
        tick();
        ctrl = 3'b010; sin_l = 1'b1;
        tick();
        sin_l = 1'b0; ctrl = 3'b000;
        n_cmp++;
        if (out !== 8'hCB || sout !== 1'b0) begin
            n_fail++;
            $display("FAIL shr: out=%h sout=%b, required cb 0", out, sout);
        end
    endtask

    task automatic test_burst_rotate();
        int n_busy;
        ctrl = 3'b011; data = 8'hA5;
        tick();
        ctrl = 3'b100; start = 1'b1; count = 4'd8;
        tick();
        start = 1'b0; ctrl = 3'b000;
        n_cmp++;
        if (out !== 8'hA5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_accept: out=%h busy=%b, required a5 1", out, busy);
        end
        n_busy = 0;
        while (busy && n_busy < 20) begin
            n_busy++;
            tick();
            if (n_busy == 1) begin
                n_cmp++;
                if (out !== 8'h4B) begin
                    n_fail++;
                    $display("FAIL rot_first_step: out=%h, required 4b", out);
                end
            end
        end
        n_cmp++;
        if (n_busy != 8 || done !== 1'b1 || out !== 8'hA5) begin
            n_fail++;
            $display("FAIL rot_burst_end: busy_cycles=%0d done=%b out=%h, required 8 1 a5",
                     n_busy, done, out);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse_width: done=%b, required 0", done);
        end
    endtask

    task automatic test_abort();
        ctrl = 3'b011; data = 8'hF0;
        tick();
        ctrl = 3'b010; start = 1'b1; count = 4'd3; sin_l = 1'b0;
        tick();
        start = 1'b0; ctrl = 3'b011; data = 8'hFF; count = 4'd9;
        tick();
        tick();
        n_cmp++;
        if (out !== 8'h3C || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: out=%h busy=%b, required 3c 1", out, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; ctrl = 3'b000;
        n_cmp++;
        if (out !== 8'h3C || busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: out=%h busy=%b done=%b sout=%b, required 3c 0 0 0",
                     out, busy, done, sout);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || out !== 8'h3C) begin
            n_fail++;
            $display("FAIL abort_no_done: done=%b out=%h, required 0 3c", done, out);
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        ctrl = 3'b011; data = 8'h5A;
        tick();
        ctrl = 3'b001; start = 1'b1; count = 4'd0;
        tick();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || out !== 8'h5A) begin
            n_fail++;
            $display("FAIL zero_count: done=%b busy=%b out=%h, required 1 0 5a", done, busy, out);
        end
        count = 4'd2; sin_r = 1'b1;
        tick();
        start = 1'b0; ctrl = 3'b000;
        n_cmp++;
        if (busy !== 1'b1 || out !== 8'h5A) begin
            n_fail++;
            $display("FAIL start_on_done: busy=%b out=%h, required 1 5a", busy, out);
        end
        guard = 0;
        while (!done && guard < 10) begin
            guard++;
            tick();
        end
        sin_r = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || out !== 8'h6B || guard != 2) begin
            n_fail++;
            $display("FAIL b2b_result: done=%b out=%h steps=%0d, required 1 6b 2",
                     done, out, guard);
        end
        ctrl = 3'b101; start = 1'b1; count = 4'd5;
        tick();
        start = 1'b0; ctrl = 3'b000;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_burst: out=%h busy=%b done=%b, required 00 0 0",
                     out, busy, done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            data  = N'($urandom);
            ctrl  = 3'($urandom_range(0, 7));
            sin_r = 1'($urandom);
            sin_l = 1'($urandom);
            start = ($urandom_range(0, 3) == 0);
            count = CNT_W'($urandom_range(0, 15));
            abort = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 99) == 0);
            tick();
            n_cmp++;
            if (out !== m_out || sout !== m_sout || busy !== (m_left > 0) || done !== m_done) begin
                n_fail++;
                $display("FAIL random[%0d]: out=%h sout=%b busy=%b done=%b, required %h %b %b %b",
                         i, out, sout, busy, done, m_out, m_sout, (m_left > 0), m_done);
            end
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0; ctrl = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_burst_rotate();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
